logic_unit_arbiter: RTL and testbench

- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
- Arbitrates round-robin and accepts one request per transaction with a valid/ready handshake.
- Drives the unit's operand and op lines from registers, waits a configurable number of cycles, then captures the result and returns it to the winning requester.
- Sits in the datapath between issue logic and the shared logic unit.

---
 rtl/logic_unit_arbiter.sv | 145 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one bitwise logic unit between two requesters
module logic_unit_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ReqValid0,
  input  logic             ReqValid1,
  output logic             ReqReady0,
  output logic             ReqReady1,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic [WIDTH-1:0] ReqB1,
  input  logic [1:0]       ReqOp0,
  input  logic [1:0]       ReqOp1,
  output logic             RespValid0,
  output logic             RespValid1,
  input  logic             RespReady0,
  input  logic             RespReady1,
  output logic [WIDTH-1:0] RespData,
  output logic             RespZero,
  output logic [WIDTH-1:0] UnitA,
  output logic [WIDTH-1:0] UnitB,
  output logic [1:0]       UnitOp,
  input  logic [WIDTH-1:0] UnitO,
  output logic             Busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] unit_a_q, unit_a_d;
  logic [WIDTH-1:0] unit_b_q, unit_b_d;
  logic [1:0]       unit_op_q, unit_op_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_valid0_q, resp_valid0_d;
  logic             resp_valid1_q, resp_valid1_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [3:0]       count_q, count_d;

  logic in_exec, in_resp, in_idle;
  logic grant_sel, accept, owner_ready;

  // Encoding 2'd3 is unreachable; it behaves exactly like IDLE.
  assign in_exec = (state_q == ST_EXEC);
  assign in_resp = (state_q == ST_RESP);
  assign in_idle = !in_exec && !in_resp;

  // With both valid the requester that was not served last wins.
  assign grant_sel   = (ReqValid0 && ReqValid1) ? !last_q : ReqValid1;
  assign ReqReady0   = in_idle && ReqValid0 && !grant_sel;
  assign ReqReady1   = in_idle && ReqValid1 && grant_sel;
  assign accept      = ReqReady0 || ReqReady1;
  assign owner_ready = owner_q ? RespReady1 : RespReady0;

  always_comb begin
    state_d       = state_q;
    unit_a_d      = unit_a_q;
    unit_b_d      = unit_b_q;
    unit_op_d     = unit_op_q;
    resp_data_d   = resp_data_q;
    resp_zero_d   = resp_zero_q;
    resp_valid0_d = resp_valid0_q;
    resp_valid1_d = resp_valid1_q;
    owner_d       = owner_q;
    last_d        = last_q;
    count_d       = count_q;
    case (state_q)
      ST_EXEC: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          resp_data_d   = UnitO;
          resp_zero_d   = (UnitO == '0);
          resp_valid0_d = !owner_q;
          resp_valid1_d = owner_q;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_ready) begin
          resp_valid0_d = 1'b0;
          resp_valid1_d = 1'b0;
          last_d        = owner_q;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          unit_a_d  = grant_sel ? ReqA1 : ReqA0;
          unit_b_d  = grant_sel ? ReqB1 : ReqB0;
          unit_op_d = grant_sel ? ReqOp1 : ReqOp0;
          owner_d   = grant_sel;
          count_d   = 4'(EXEC_CYCLES - 1);
          state_d   = ST_EXEC;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      unit_a_q      <= '0;
      unit_b_q      <= '0;
      unit_op_q     <= 2'b00;
      resp_data_q   <= '0;
      resp_zero_q   <= 1'b0;
      resp_valid0_q <= 1'b0;
      resp_valid1_q <= 1'b0;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      count_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      unit_a_q      <= unit_a_d;
      unit_b_q      <= unit_b_d;
      unit_op_q     <= unit_op_d;
      resp_data_q   <= resp_data_d;
      resp_zero_q   <= resp_zero_d;
      resp_valid0_q <= resp_valid0_d;
      resp_valid1_q <= resp_valid1_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      count_q       <= count_d;
    end
  end

  assign UnitA      = unit_a_q;
  assign UnitB      = unit_b_q;
  assign UnitOp     = unit_op_q;
  assign RespData   = resp_data_q;
  assign RespZero   = resp_zero_q;
  assign RespValid0 = resp_valid0_q;
  assign RespValid1 = resp_valid1_q;
  assign Busy       = in_exec || in_resp;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb/tb_logic_unit_arbiter.sv - randomized and directed checks of logic_unit_arbiter against a transaction model
module tb_logic_unit_arbiter;

  localparam int EXEC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rv0 = 1'b0, rv1 = 1'b0, rr0 = 1'b0, rr1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic        ReqReady0, ReqReady1, RespValid0, RespValid1, RespZero, Busy;
  logic [31:0] RespData, UnitA, UnitB, UnitO;
  logic [1:0]  UnitOp;

  logic        x_rv = 1'b0, x_rr = 1'b0;
  logic [31:0] x_a = '0, x_b = '0;
  logic [1:0]  x_op = '0;
  logic        x_rdy0, x_rdy1, x_vld0, x_vld1, x_zero, x_busy;
  logic [31:0] x_data, x_ua, x_ub, x_uo;
  logic [1:0]  x_uop;

  int n_err = 0;
  int n_checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] lu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  assign UnitO = lu(UnitA, UnitB, UnitOp);
  assign x_uo  = lu(x_ua, x_ub, x_uop);

  logic_unit_arbiter #(.WIDTH(32), .EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid0(rv0), .ReqValid1(rv1), .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
    .ReqA0(a0), .ReqA1(a1), .ReqB0(b0), .ReqB1(b1), .ReqOp0(op0), .ReqOp1(op1),
    .RespValid0(RespValid0), .RespValid1(RespValid1), .RespReady0(rr0), .RespReady1(rr1),
    .RespData(RespData), .RespZero(RespZero),
    .UnitA(UnitA), .UnitB(UnitB), .UnitOp(UnitOp), .UnitO(UnitO), .Busy(Busy)
  );

  logic_unit_arbiter #(.WIDTH(32), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ReqValid0(x_rv), .ReqValid1(1'b0), .ReqReady0(x_rdy0), .ReqReady1(x_rdy1),
    .ReqA0(x_a), .ReqA1(32'h0), .ReqB0(x_b), .ReqB1(32'h0), .ReqOp0(x_op), .ReqOp1(2'b00),
    .RespValid0(x_vld0), .RespValid1(x_vld1), .RespReady0(x_rr), .RespReady1(1'b0),
    .RespData(x_data), .RespZero(x_zero),
    .UnitA(x_ua), .UnitB(x_ub), .UnitOp(x_uop), .UnitO(x_uo), .Busy(x_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one job in flight, a timer until its result is posted.
  bit          m_active, m_resp, m_owner, m_last, m_rzero, m_acc0, m_acc1;
  int          m_timer;
  logic [31:0] m_ua, m_ub, m_res, m_rdata;
  logic [1:0]  m_uop;
  logic        exp_rdy0, exp_rdy1;

  assign exp_rdy0 = !m_active && rv0 && (!rv1 || m_last == 1'b1);
  assign exp_rdy1 = !m_active && rv1 && (!rv0 || m_last == 1'b0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_resp <= 0; m_owner <= 0; m_last <= 1; m_rzero <= 0;
      m_acc0 <= 0; m_acc1 <= 0; m_timer <= 0;
      m_ua <= '0; m_ub <= '0; m_uop <= '0; m_res <= '0; m_rdata <= '0;
    end else begin
      m_acc0 <= exp_rdy0;
      m_acc1 <= exp_rdy1;
      if (!m_active) begin
        if (exp_rdy0 || exp_rdy1) begin
          m_active <= 1;
          m_timer  <= EXEC;
          m_owner  <= exp_rdy1;
          m_ua     <= exp_rdy1 ? a1 : a0;
          m_ub     <= exp_rdy1 ? b1 : b0;
          m_uop    <= exp_rdy1 ? op1 : op0;
          m_res    <= exp_rdy1 ? lu(a1, b1, op1) : lu(a0, b0, op0);
        end
      end else if (!m_resp) begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) begin
          m_resp  <= 1;
          m_rdata <= m_res;
          m_rzero <= (m_res == 32'h0);
        end
      end else if (m_owner ? rr1 : rr0) begin
        m_resp   <= 0;
        m_active <= 0;
        m_last   <= m_owner;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ReqReady0", 32'(ReqReady0), 32'(exp_rdy0));
      check("ReqReady1", 32'(ReqReady1), 32'(exp_rdy1));
      check("RespValid0", 32'(RespValid0), 32'(m_resp && !m_owner));
      check("RespValid1", 32'(RespValid1), 32'(m_resp && m_owner));
      check("RespData", RespData, m_rdata);
      check("RespZero", 32'(RespZero), 32'(m_rzero));
      check("UnitA", UnitA, m_ua);
      check("UnitB", UnitB, m_ub);
      check("UnitOp", 32'(UnitOp), 32'(m_uop));
      check("Busy", 32'(Busy), 32'(m_active));
    end
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic do_one(input bit who, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp_d, input logic exp_z, input string name);
    int n;
    @(posedge clk); #1;
    if (!who) begin rv0 = 1; a0 = a; b0 = b; op0 = op; rr0 = 1; end
    else      begin rv1 = 1; a1 = a; b1 = b; op1 = op; rr1 = 1; end
    n = 0;
    do begin @(negedge clk); n++; end while (!(who ? ReqReady1 : ReqReady0) && n < 10);
    check({name, "_grant"}, 32'(who ? ReqReady1 : ReqReady0), 32'h1);
    @(posedge clk); #1;
    if (!who) rv0 = 0; else rv1 = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(who ? RespValid1 : RespValid0) && n < 20);
    check({name, "_valid"}, 32'(who ? RespValid1 : RespValid0), 32'h1);
    check({name, "_data"}, RespData, exp_d);
    check({name, "_zero"}, 32'(RespZero), 32'(exp_z));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int grants[$];

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_rv", 32'({RespValid1, RespValid0}), 32'h0);
    check("rst_unit", UnitA | UnitB | 32'(UnitOp), 32'h0);
    check("rst_resp", RespData | 32'(RespZero), 32'h0);
    chk_en = 1'b1;
    @(negedge clk); #2 rst_n = 1'b1;

    // Single request: NOR 0x0000FFFF, 0x00FF00FF
    @(posedge clk); #1;
    rv0 = 1; a0 = 32'h0000FFFF; b0 = 32'h00FF00FF; op0 = 2'b11; rr0 = 1;
    @(negedge clk);
    check("single_rdy", 32'(ReqReady0), 32'h1);
    @(posedge clk); #1 rv0 = 0;
    @(negedge clk);
    check("single_rdy_drop", 32'(ReqReady0), 32'h0);
    check("single_early", 32'(RespValid0), 32'h0);
    @(negedge clk);
    check("single_valid", 32'(RespValid0), 32'h1);
    check("single_data", RespData, 32'hFF000000);
    check("single_zero", 32'(RespZero), 32'h0);
    check("single_other", 32'(RespValid1), 32'h0);
    @(posedge clk); #1;

    do_one(0, 32'h0, 32'h0, 2'b01, 32'h0, 1'b1, "zero_or");
    do_one(1, 32'hFFFFFFFF, 32'h0, 2'b11, 32'h0, 1'b1, "zero_nor");

    // Backpressure on requester 1 while requester 0 waits
    @(posedge clk); #1;
    rr1 = 0; rr0 = 1; rv1 = 1; a1 = 32'h0F0F0F0F; b1 = 32'h00FF00FF; op1 = 2'b10;
    n = 0;
    do begin @(negedge clk); n++; end while (!ReqReady1 && n < 10);
    check("bp_grant", 32'(ReqReady1), 32'h1);
    @(posedge clk); #1;
    rv1 = 0; rv0 = 1; a0 = 32'h12340000; b0 = 32'hFFFF0000; op0 = 2'b00;
    n = 0;
    do begin @(negedge clk); n++; end while (!RespValid1 && n < 10);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("bp_hold_valid", 32'(RespValid1), 32'h1);
      check("bp_hold_data", RespData, 32'h0FF00FF0);
      check("bp_block_rdy", 32'(ReqReady0), 32'h0);
    end
    @(posedge clk); #1 rr1 = 1;
    @(negedge clk);
    check("bp_release_rdy", 32'(ReqReady0), 32'h0);
    @(negedge clk);
    check("bp_next_grant", 32'(ReqReady0), 32'h1);
    check("bp_cleared", 32'(RespValid1), 32'h0);
    @(posedge clk); #1 rv0 = 0;
    repeat (4) @(posedge clk);
    #1;

    // Tie from reset: grants alternate starting with requester 0
    do_reset();
    @(posedge clk); #1;
    rv0 = 1; a0 = 32'hF0F0F0F0; b0 = 32'hFFFF0000; op0 = 2'b00; rr0 = 1;
    rv1 = 1; a1 = 32'hAAAAAAAA; b1 = 32'h55555555; op1 = 2'b10; rr1 = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (ReqReady0) grants.push_back(0);
      if (ReqReady1) grants.push_back(1);
      if (RespValid0) check("tie_data0", RespData, 32'hF0F00000);
      if (RespValid1) check("tie_data1", RespData, 32'hFFFFFFFF);
    end
    check("tie_count", 32'(grants.size() >= 4), 32'h1);
    if (grants.size() >= 4)
      for (int g = 0; g < 4; g++) check("tie_order", 32'(grants[g]), 32'(g % 2));
    @(posedge clk); #1 rv0 = 0; rv1 = 0;
    repeat (4) @(posedge clk);
    #1;

    // EXEC_CYCLES=4 instance: operands held 4 cycles, later ReqA change ignored
    x_rv = 1; x_a = 32'h12345678; x_b = 32'h0F0F0F0F; x_op = 2'b01; x_rr = 1;
    @(negedge clk);
    check("p4_rdy", 32'(x_rdy0), 32'h1);
    @(posedge clk); #1 x_rv = 0; x_a = 32'hFFFFFFFF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("p4_unit_a", x_ua, 32'h12345678);
      check("p4_unit_b", x_ub, 32'h0F0F0F0F);
      check("p4_unit_op", 32'(x_uop), 32'h1);
      check("p4_not_yet", 32'(x_vld0), 32'h0);
    end
    @(negedge clk);
    check("p4_valid", 32'(x_vld0), 32'h1);
    check("p4_data", x_data, 32'h1F3F5F7F);
    check("p4_other", 32'(x_vld1 | x_rdy1), 32'h0);
    @(posedge clk); #1;

    // Async reset in the middle of EXEC
    rv0 = 1; a0 = 32'hDEADBEEF; b0 = 32'hFFFFFFFF; op0 = 2'b00; rr0 = 1;
    @(negedge clk);
    check("ar_rdy", 32'(ReqReady0), 32'h1);
    @(posedge clk); #1 rv0 = 0;
    @(negedge clk); #2 rst_n = 0;
    #1;
    check("ar_busy", 32'(Busy), 32'h0);
    check("ar_unit", UnitA | UnitB | 32'(UnitOp), 32'h0);
    check("ar_resp", RespData | 32'({RespValid1, RespValid0, RespZero}), 32'h0);
    @(posedge clk); #1;
    rv0 = 1; rv1 = 1;
    @(negedge clk); #2 rst_n = 1;
    #1;
    check("ar_first0", 32'(ReqReady0), 32'h1);
    check("ar_first1", 32'(ReqReady1), 32'h0);

    // Randomized traffic with protocol-respecting requesters
    repeat (3000) begin
      @(posedge clk); #1;
      if (!rv0 || m_acc0) begin
        rv0 = ($urandom_range(0, 2) != 0); a0 = rnd_opnd(); b0 = rnd_opnd(); op0 = 2'($urandom_range(0, 3));
      end
      if (!rv1 || m_acc1) begin
        rv1 = ($urandom_range(0, 2) != 0); a1 = rnd_opnd(); b1 = rnd_opnd(); op1 = 2'($urandom_range(0, 3));
      end
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 rv0 = 0; rv1 = 0; rr0 = 1; rr1 = 1;
    repeat (6) @(posedge clk);
    #1;
    check("drain_busy", 32'(Busy), 32'h0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
